// File: rtl/output_fifo.sv
// Write-enable to AXI-Stream FIFO with first-word fall-through and a free-space count.
// Full/empty decisions use start-of-cycle occupancy, so a write into a full FIFO is dropped even during a read.
module output_fifo #(
    parameter int OUTW  = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [OUTW-1:0]            data_in,
    input  logic                       wr_en,
    output logic [$clog2(DEPTH+1)-1:0] capacity,
    output logic [OUTW-1:0]            AXIS_TDATA,
    output logic                       AXIS_TVALID,
    input  logic                       AXIS_TREADY
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [OUTW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_fire, rd_fire;

    assign AXIS_TVALID = (count_q != '0);
    assign AXIS_TDATA  = mem_q[rd_ptr_q];
    assign capacity    = CW'(DEPTH) - count_q;

    assign wr_fire = wr_en && (count_q != CW'(DEPTH));
    assign rd_fire = AXIS_TVALID && AXIS_TREADY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_fire && !rd_fire) begin
            count_d = count_q + 1'b1;
        end else if (rd_fire && !wr_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_output_fifo.sv
// Directed and randomized checks of output_fifo at OUTW=16, DEPTH=16.
module tb_output_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        wr_en;
    logic [4:0]  capacity;
    logic [15:0] AXIS_TDATA;
    logic        AXIS_TVALID;
    logic        AXIS_TREADY;

    int errs   = 0;
    int checks = 0;

    output_fifo #(.OUTW(16), .DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .capacity    (capacity),
        .AXIS_TDATA  (AXIS_TDATA),
        .AXIS_TVALID (AXIS_TVALID),
        .AXIS_TREADY (AXIS_TREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_idx, rd_idx, cnt, cyc;
        logic fw, fr;

        reset = 1'b1; wr_en = 1'b0; data_in = '0; AXIS_TREADY = 1'b0;
        #1;
        chk("rst_cap", capacity, 16);
        chk("rst_valid", AXIS_TVALID, 0);
        step(); step();
        reset = 1'b0;
        step();

        // Fill to full with backpressure, then an ignored extra write.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 16'(i);
            step();
            chk("fill_cap", capacity, 15 - i);
        end
        data_in = 16'd99;
        step();
        wr_en = 1'b0;
        chk("full_cap", capacity, 0);
        AXIS_TREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", AXIS_TVALID, 1);
            chk("drain_data", AXIS_TDATA, i);
            step();
        end
        AXIS_TREADY = 1'b0;
        chk("drained_cap", capacity, 16);
        chk("drained_valid", AXIS_TVALID, 0);

        // Single word latency.
        wr_en = 1'b1; data_in = 16'h1234;
        step();
        wr_en = 1'b0;
        chk("single_valid", AXIS_TVALID, 1);
        chk("single_data", AXIS_TDATA, 16'h1234);
        AXIS_TREADY = 1'b1;
        step();
        AXIS_TREADY = 1'b0;
        chk("single_empty", AXIS_TVALID, 0);
        chk("single_cap", capacity, 16);

        // Full with simultaneous read and write: only the read happens.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 16'(200 + i);
            step();
        end
        data_in = 16'd100; AXIS_TREADY = 1'b1;
        step();
        wr_en = 1'b0;
        chk("fullrw_cap", capacity, 1);
        for (int i = 1; i < 16; i++) begin
            chk("fullrw_data", AXIS_TDATA, 200 + i);
            step();
        end
        AXIS_TREADY = 1'b0;
        chk("fullrw_nodrop", AXIS_TVALID, 0);

        // Half full, streaming for 40 cycles across pointer wraps.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = 16'(i);
            step();
        end
        AXIS_TREADY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("stream_data", AXIS_TDATA, i);
            data_in = 16'(i + 8);
            step();
            chk("stream_cap", capacity, 8);
        end
        wr_en = 1'b0;
        for (int i = 40; i < 48; i++) begin
            chk("stream_tail", AXIS_TDATA, i);
            step();
        end
        AXIS_TREADY = 1'b0;
        chk("stream_empty", AXIS_TVALID, 0);

        // Asynchronous reset with 5 words stored.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; data_in = 16'(50 + i);
            step();
        end
        wr_en = 1'b0;
        chk("pre_rst_cap", capacity, 11);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_cap", capacity, 16);
        chk("async_rst_valid", AXIS_TVALID, 0);
        step();
        reset = 1'b0;
        step();

        // Randomized: alternating fill-heavy and drain-heavy phases.
        wr_idx = 0; rd_idx = 0; cnt = 0; cyc = 0;
        while (rd_idx < 10000 && cyc < 90000) begin
            if ((cyc / 20) % 2 == 0) begin
                wr_en       = ($urandom_range(0, 99) < 99) && (wr_idx < 10000);
                AXIS_TREADY = ($urandom_range(0, 99) < 1);
            end else begin
                wr_en       = ($urandom_range(0, 99) < 1) && (wr_idx < 10000);
                AXIS_TREADY = ($urandom_range(0, 99) < 99);
            end
            data_in = 16'(wr_idx);
            fw = wr_en && (cnt != 16);
            fr = AXIS_TREADY && (cnt != 0);
            if (fr) chk("rand_data", AXIS_TDATA, 16'(rd_idx));
            step();
            if (fw) wr_idx++;
            if (fr) rd_idx++;
            cnt = cnt + (fw ? 1 : 0) - (fr ? 1 : 0);
            cyc++;
        end
        wr_en = 1'b0; AXIS_TREADY = 1'b0;
        chk("rand_count", rd_idx, 10000);
        chk("rand_cap", capacity, 16);
        chk("rand_valid", AXIS_TVALID, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
